// File: rtl/reg_write_sequencer_pkg.sv
// Shared types and default sizes for the register-write sequencer.
// Default widths match the 4x8 register file this block feeds.
package reg_write_sequencer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DEPTH  = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] idx;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Request, register-file write, read-bypass and status signals of the sequencer.
// The sequencer is the slave; the datapath that issues requests is the master.
interface reg_write_sequencer_if
  import reg_write_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              aluValid;
  logic [ADDR_W-1:0] aluReg;
  logic [DATA_W-1:0] aluData;
  logic              memValid;
  logic [ADDR_W-1:0] memReg;
  logic [DATA_W-1:0] memData;
  logic              isWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] read1;
  logic [ADDR_W-1:0] read2;
  logic [DATA_W-1:0] rfReg1;
  logic [DATA_W-1:0] rfReg2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic              stall;
  logic [ADDR_W:0]   pending;
  logic              overflow;

  modport slave (
    input  aluValid, aluReg, aluData, memValid, memReg, memData,
    input  read1, read2, rfReg1, rfReg2,
    output isWrite, writeReg, writeData, fwd1, fwd2, stall, pending, overflow
  );

  modport master (
    output aluValid, aluReg, aluData, memValid, memReg, memData,
    output read1, read2, rfReg1, rfReg2,
    input  isWrite, writeReg, writeData, fwd1, fwd2, stall, pending, overflow
  );
endinterface

// File: rtl/reg_write_sequencer_wr_queue.sv
// Dual-push / single-pop circular FIFO of pending register writes.
// Push A lands before push B; the caller only pushes what fits.
module wr_queue
  import reg_write_sequencer_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_a,
  input  wr_req_t          i_req_a,
  input  logic             i_push_b,
  input  wr_req_t          i_req_b,
  input  logic             i_pop,
  output wr_req_t          o_head,
  output logic [CNT_W-1:0] o_count,
  output logic [PTR_W-1:0] o_head_ptr,
  output wr_req_t          o_entries [DEPTH]
);

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_tail_b;
  logic [1:0]       w_n_push;

  assign w_tail_b = r_tail + PTR_W'(i_push_a);
  assign w_n_push = 2'(i_push_a) + 2'(i_push_b);

  // NOTE: storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (i_push_a) r_mem[r_tail]   <= i_req_a;
    if (i_push_b) r_mem[w_tail_b] <= i_req_b;
  end

  // NOTE: non-blocking updates so every pointer reads its pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_n_push);
      r_head  <= r_head + PTR_W'(i_pop);
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(i_pop);
    end
  end

  assign o_head     = r_mem[r_head];
  assign o_count    = r_count;
  assign o_head_ptr = r_head;
  assign o_entries  = r_mem;

endmodule

// File: rtl/reg_write_sequencer.sv
// Queues ALU/load register writes, drains one per cycle to the register file
// and forwards still-queued values to the two read ports.
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic                  CLK,
  input logic                  Reset,
  reg_write_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_req_t           w_head;
  wr_req_t           w_entries [DEPTH];
  wr_req_t           w_req_mem;
  wr_req_t           w_req_alu;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_free;
  logic [PTR_W-1:0]  w_head_ptr;
  logic              w_pop;
  logic              w_acc_mem;
  logic              w_acc_alu;
  logic              w_drop;
  logic [DATA_W-1:0] w_fwd1;
  logic [DATA_W-1:0] w_fwd2;
  logic              r_overflow;

  assign w_req_mem = '{idx: bus.memReg, data: bus.memData};
  assign w_req_alu = '{idx: bus.aluReg, data: bus.aluData};

  // The head leaves at the same edge the new entries arrive, so its slot counts as free.
  assign w_pop     = (w_count != '0);
  assign w_free    = CNT_W'(DEPTH) - w_count + CNT_W'(w_pop);
  assign w_acc_mem = bus.memValid && (w_free != '0);
  assign w_acc_alu = bus.aluValid && (w_free > CNT_W'(w_acc_mem));
  assign w_drop    = (bus.memValid && !w_acc_mem) || (bus.aluValid && !w_acc_alu);

  wr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (CLK),
    .rst        (Reset),
    .i_push_a   (w_acc_mem),
    .i_req_a    (w_req_mem),
    .i_push_b   (w_acc_alu),
    .i_req_b    (w_req_alu),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_head_ptr (w_head_ptr),
    .o_entries  (w_entries)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_overflow <= 1'b0;
    else       r_overflow <= r_overflow | w_drop;
  end

  // Walk oldest to youngest so the last match wins.
  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    w_fwd1 = bus.rfReg1;
    w_fwd2 = bus.rfReg2;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < w_count) begin
        if (w_entries[w_head_ptr + PTR_W'(i)].idx == bus.read1)
          w_fwd1 = w_entries[w_head_ptr + PTR_W'(i)].data;
        if (w_entries[w_head_ptr + PTR_W'(i)].idx == bus.read2)
          w_fwd2 = w_entries[w_head_ptr + PTR_W'(i)].data;
      end
    end
  end

  // Stale storage is masked so the write port idles at zero when empty.
  assign bus.isWrite   = w_pop;
  assign bus.writeReg  = w_pop ? w_head.idx  : '0;
  assign bus.writeData = w_pop ? w_head.data : '0;
  assign bus.fwd1      = w_fwd1;
  assign bus.fwd2      = w_fwd2;
  assign bus.stall     = (CNT_W'(DEPTH) - w_count) < CNT_W'(2);
  assign bus.pending   = (ADDR_W + 1)'(w_count);
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer: ordering, bypass, back-pressure,
// overflow, pointer wrap and asynchronous reset.
module tb_reg_write_sequencer;

  typedef struct {
    logic [1:0] r;
    logic [7:0] d;
  } ent_t;

  logic CLK = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q [$];
  bit   exp_ovf = 1'b0;
  logic [7:0] rf   [4] = '{default: 8'h00};
  logic [7:0] snap [4];

  always #5 CLK = ~CLK;

  reg_write_sequencer_if bus ();

  reg_write_sequencer dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Register file model: captures the write port on the rising edge.
  assign bus.rfReg1 = rf[bus.read1];
  assign bus.rfReg2 = rf[bus.read2];
  always @(posedge CLK) if (bus.isWrite) rf[bus.writeReg] <= bus.writeData;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock: check the head against the expected order, drive requests, step.
  task automatic cycle(input logic mv, input logic [1:0] mr, input logic [7:0] md,
                       input logic av, input logic [1:0] ar, input logic [7:0] ad);
    int free;
    bit pop;
    pop = (exp_q.size() != 0);
    check("isWrite", 32'(bus.isWrite), 32'(pop));
    if (pop) begin
      check("writeReg",  32'(bus.writeReg),  32'(exp_q[0].r));
      check("writeData", 32'(bus.writeData), 32'(exp_q[0].d));
      void'(exp_q.pop_front());
    end
    free = 4 - exp_q.size();
    bus.memValid = mv; bus.memReg = mr; bus.memData = md;
    bus.aluValid = av; bus.aluReg = ar; bus.aluData = ad;
    if (mv) begin
      if (free > 0) begin exp_q.push_back('{mr, md}); free--; end
      else exp_ovf = 1'b1;
    end
    if (av) begin
      if (free > 0) begin exp_q.push_back('{ar, ad}); free--; end
      else exp_ovf = 1'b1;
    end
    @(posedge CLK);
    #1;
    bus.memValid = 1'b0;
    bus.aluValid = 1'b0;
    @(negedge CLK);
    check("pending",  32'(bus.pending),  32'(exp_q.size()));
    check("stall",    32'(bus.stall),    32'((4 - exp_q.size()) < 2));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    Reset = 1'b1;
    bus.memValid = 1'b0; bus.memReg = '0; bus.memData = '0;
    bus.aluValid = 1'b0; bus.aluReg = '0; bus.aluData = '0;
    bus.read1 = '0; bus.read2 = '0;
    #2;
    check("rst_isWrite",   32'(bus.isWrite),   32'd0);
    check("rst_writeReg",  32'(bus.writeReg),  32'd0);
    check("rst_writeData", 32'(bus.writeData), 32'd0);
    check("rst_pending",   32'(bus.pending),   32'd0);
    check("rst_stall",     32'(bus.stall),     32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // Single ALU write: visible on the write port in the following cycle.
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h5A);
    check("alu_isWrite",   32'(bus.isWrite),   32'd1);
    check("alu_writeReg",  32'(bus.writeReg),  32'd2);
    check("alu_writeData", 32'(bus.writeData), 32'h5A);
    idle();
    check("alu_rf2", 32'(rf[2]), 32'h5A);

    // Dual push to the same register: mem first, alu youngest.
    cycle(1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 8'h22);
    bus.read1 = 2'd1;
    #1;
    check("dual_fwd1_both", 32'(bus.fwd1), 32'h22);
    idle();
    check("dual_rf1_first", 32'(rf[1]), 32'h11);
    check("dual_fwd1_head", 32'(bus.fwd1), 32'h22);
    idle();
    check("dual_rf1_final", 32'(rf[1]), 32'h22);
    check("dual_fwd1_rf",   32'(bus.fwd1), 32'h22);

    // Forward versus register file on port 2.
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h33);
    idle();
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h44);
    bus.read2 = 2'd2;
    #1;
    check("fwd2_from_rf", 32'(bus.fwd2), 32'h33);
    bus.read2 = 2'd3;
    #1;
    check("fwd2_from_q", 32'(bus.fwd2), 32'h44);
    idle();

    // Back-pressure: two per cycle until stall rises.
    cycle(1'b1, 2'd0, 8'hA0, 1'b1, 2'd1, 8'hA1);
    check("bp_stall_lo", 32'(bus.stall), 32'd0);
    cycle(1'b1, 2'd2, 8'hA2, 1'b1, 2'd3, 8'hA3);
    check("bp_pending3", 32'(bus.pending), 32'd3);
    check("bp_stall_hi", 32'(bus.stall), 32'd1);
    check("bp_no_ovf",   32'(bus.overflow), 32'd0);

    // Fill to DEPTH, then a dual push that cannot fit entirely.
    cycle(1'b1, 2'd0, 8'hB0, 1'b1, 2'd1, 8'hB1);
    check("full_pending", 32'(bus.pending), 32'd4);
    cycle(1'b1, 2'd2, 8'hC0, 1'b1, 2'd3, 8'hC1);
    check("ovf_set",     32'(bus.overflow), 32'd1);
    check("ovf_pending", 32'(bus.pending), 32'd4);
    for (int k = 0; k < 5; k++) idle();
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_rf2",    32'(rf[2]), 32'hC0);

    // Mixed traffic to exercise pointer wrap.
    for (int i = 0; i < 12; i++) begin
      cycle((i % 3) == 0, 2'(i), 8'(8'h60 + i), 1'b1, 2'(i + 1), 8'(8'h80 + i));
    end
    for (int k = 0; k < 6; k++) idle();
    check("wrap_empty", 32'(bus.pending), 32'd0);

    // Reset mid-stream with three entries queued.
    cycle(1'b1, 2'd0, 8'hD0, 1'b1, 2'd1, 8'hD1);
    cycle(1'b1, 2'd2, 8'hD2, 1'b1, 2'd3, 8'hD3);
    check("pre_rst_pending", 32'(bus.pending), 32'd3);
    for (int k = 0; k < 4; k++) snap[k] = rf[k];
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_isWrite",  32'(bus.isWrite),  32'd0);
    check("mid_rst_pending",  32'(bus.pending),  32'd0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) idle();
    for (int k = 0; k < 4; k++) check($sformatf("post_rst_rf%0d", k), 32'(rf[k]), 32'(snap[k]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
